// File: rtl/mem_stage.sv
// Memory stage: EX/MEM latch, LW/SW/CALL/RET data-memory access over a ready
// handshake, registered writeback to WB. Optional access timeout: MEM_TIMEOUT_EN.
module mem_stage #(
  parameter int          TIMEOUT_CYCLES = 15,
  parameter logic [15:0] ERR_DATA       = 16'hDEAD
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [15:0] ex_result,
  input  logic [15:0] ex_rt,
  input  logic [15:0] ex_instr,
  output logic        mem_stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [15:0] dmem_addr,
  output logic [15:0] dmem_wdata,
  input  logic [15:0] dmem_rdata,
  input  logic        dmem_ready,
  output logic        wb_valid,
  output logic [15:0] wb_data,
  output logic [3:0]  wb_dst,
  output logic        wb_we,
  output logic        wb_ret,
  output logic        mem_err
);

  localparam logic [3:0] OP_LW   = 4'h8;
  localparam logic [3:0] OP_SW   = 4'h9;
  localparam logic [3:0] OP_B    = 4'hC;
  localparam logic [3:0] OP_CALL = 4'hD;
  localparam logic [3:0] OP_RET  = 4'hE;

  typedef enum logic {IDLE, ACCESS} state_t;
  state_t state, next_state;

  logic [3:0]  op_p0;
  logic [15:0] result_p0;
  logic [3:0]  ex_op;
  logic        ex_is_mem, ex_is_store, load_p0;
  logic        timeout, done;
  logic        unused_instr;

  assign ex_op        = ex_instr[15:12];
  assign ex_is_store  = (ex_op == OP_SW) || (ex_op == OP_CALL);
  assign ex_is_mem    = ex_is_store || (ex_op == OP_LW) || (ex_op == OP_RET);
  assign load_p0      = (op_p0 == OP_LW) || (op_p0 == OP_RET);
  assign unused_instr = ^ex_instr[7:0];

  assign mem_stall = (state == ACCESS);
  assign done      = (state == ACCESS) && (dmem_ready || timeout);

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 4) ? $clog2(TIMEOUT_CYCLES + 1) : 4;
  logic [CNT_W-1:0] wait_cnt;

  // Timeout fires on the edge that would bring the wait count up to TIMEOUT_CYCLES.
  assign timeout = (state == ACCESS) && !dmem_ready &&
                   (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      if (state == IDLE)
        wait_cnt <= '0;
      else if (!dmem_ready)
        wait_cnt <= wait_cnt + 1'b1;
      if (timeout)
        mem_err <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
  assign mem_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (ex_valid && ex_is_mem) next_state = ACCESS;
      ACCESS:  if (dmem_ready || timeout) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // EX/MEM latch -> memory request / writeback
  always_ff @(posedge clk) begin
    if (rst) begin
      op_p0      <= '0;
      result_p0  <= '0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      wb_valid   <= 1'b0;
      wb_data    <= '0;
      wb_dst     <= '0;
      wb_we      <= 1'b0;
      wb_ret     <= 1'b0;
    end else if (state == IDLE) begin
      op_p0     <= ex_op;
      result_p0 <= ex_result;
      wb_dst    <= ex_instr[11:8];
      wb_data   <= ex_result;
      wb_ret    <= 1'b0;
      if (ex_valid && ex_is_mem) begin
        dmem_req   <= 1'b1;
        dmem_we    <= ex_is_store;
        dmem_addr  <= ex_result;
        dmem_wdata <= ex_rt;
        wb_valid   <= 1'b0;
        wb_we      <= 1'b0;
      end else begin
        wb_valid <= ex_valid;
        wb_we    <= ex_valid && (ex_op != OP_B);
      end
    end else begin
      wb_valid <= done;
      if (done) begin
        dmem_req <= 1'b0;
        dmem_we  <= 1'b0;
        wb_we    <= (op_p0 == OP_LW);
        wb_ret   <= (op_p0 == OP_RET);
        if (load_p0)
          wb_data <= dmem_ready ? dmem_rdata : ERR_DATA;
        else
          wb_data <= result_p0;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Randomized self-checking bench for mem_stage against a spec-level model
// of writeback results and memory-bus behaviour.
module tb_mem_stage;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_LW   = 4'h8;
  localparam logic [3:0] OP_SW   = 4'h9;
  localparam logic [3:0] OP_B    = 4'hC;
  localparam logic [3:0] OP_CALL = 4'hD;
  localparam logic [3:0] OP_RET  = 4'hE;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic [15:0] ex_result, ex_rt, ex_instr;
  logic        mem_stall, dmem_req, dmem_we;
  logic [15:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_ready;
  logic        wb_valid;
  logic [15:0] wb_data;
  logic [3:0]  wb_dst;
  logic        wb_we, wb_ret, mem_err;

  int n_cmp = 0;
  int n_bad = 0;

  logic [3:0] alu_ops [11] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'hA, 4'hB, 4'hC};
  logic [3:0] mem_ops [4]  = '{OP_LW, OP_SW, OP_CALL, OP_RET};

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_result(ex_result), .ex_rt(ex_rt),
    .ex_instr(ex_instr), .mem_stall(mem_stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .dmem_ready(dmem_ready), .wb_valid(wb_valid), .wb_data(wb_data), .wb_dst(wb_dst),
    .wb_we(wb_we), .wb_ret(wb_ret), .mem_err(mem_err)
  );

  function automatic logic is_store(input logic [3:0] op);
    return (op == OP_SW) || (op == OP_CALL);
  endfunction

  function automatic logic is_load(input logic [3:0] op);
    return (op == OP_LW) || (op == OP_RET);
  endfunction

  task automatic test_reset();
    logic [63:0] got;
    rst = 1'b1; ex_valid = 1'b1; ex_instr = {OP_LW, 4'h5, 8'h00};
    ex_result = 16'h1111; ex_rt = 16'h2222; dmem_ready = 1'b1; dmem_rdata = 16'h3333;
    repeat (3) @(posedge clk);
    #1;
    got = {mem_stall, dmem_req, dmem_we, dmem_addr, dmem_wdata, wb_valid, wb_data, wb_dst, wb_we, wb_ret, mem_err};
    n_cmp++;
    if (got !== 64'd0) begin n_bad++; $display("FAIL reset_outputs: got %h want 0", got); end
    @(negedge clk);
    rst = 1'b0; ex_valid = 1'b0; dmem_ready = 1'b0;
  endtask

  task automatic test_alu();
    logic [3:0] op, dst;
    logic [15:0] res;
    logic v, exp_we;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      op  = alu_ops[$urandom_range(0, 10)];
      dst = 4'($urandom);
      res = 16'($urandom);
      v   = ($urandom_range(0, 3) != 0);
      ex_valid = v; ex_instr = {op, dst, 8'($urandom)}; ex_result = res; ex_rt = 16'($urandom);
      dmem_ready = 1'($urandom);
      exp_we = v && (op != OP_B);
      @(posedge clk); #1;
      n_cmp++;
      if (wb_valid !== v) begin n_bad++; $display("FAIL alu_valid[%0d]: got %b want %b", i, wb_valid, v); end
      n_cmp++;
      if (wb_we !== exp_we) begin n_bad++; $display("FAIL alu_we[%0d]: got %b want %b", i, wb_we, exp_we); end
      n_cmp++;
      if ({mem_stall, dmem_req, wb_ret} !== 3'b000) begin
        n_bad++; $display("FAIL alu_ctrl[%0d]: got %b want 000", i, {mem_stall, dmem_req, wb_ret});
      end
      if (v) begin
        n_cmp++;
        if ({wb_data, wb_dst} !== {res, dst}) begin
          n_bad++; $display("FAIL alu_data[%0d]: got %h/%h want %h/%h", i, wb_data, wb_dst, res, dst);
        end
      end
    end
    dmem_ready = 1'b0;
  endtask

  // One memory instruction: accept, `delay` non-ready ACCESS edges, then completion.
  task automatic mem_txn(input logic [3:0] op, input logic [15:0] res, input logic [15:0] rt,
                         input logic [3:0] dst, input int delay, input logic [15:0] rdata);
    logic [15:0] exp_data;
    @(negedge clk);
    ex_valid = 1'b1; ex_instr = {op, dst, 8'($urandom)}; ex_result = res; ex_rt = rt;
    dmem_ready = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k <= delay; k++) begin
      n_cmp++;
      if ({mem_stall, dmem_req, dmem_we, dmem_addr, dmem_wdata, wb_valid} !==
          {1'b1, 1'b1, is_store(op), res, rt, 1'b0}) begin
        n_bad++;
        $display("FAIL access_bus op%h cyc%0d: got stall%b req%b we%b a%h d%h v%b want we%b a%h d%h",
                 op, k, mem_stall, dmem_req, dmem_we, dmem_addr, dmem_wdata, wb_valid, is_store(op), res, rt);
      end
      @(negedge clk);
      ex_valid = 1'b0; ex_result = 16'($urandom); ex_rt = 16'($urandom); ex_instr = 16'($urandom);
      if (k < delay) begin dmem_ready = 1'b0; dmem_rdata = 16'($urandom); end
      else begin dmem_ready = 1'b1; dmem_rdata = rdata; end
      @(posedge clk); #1;
    end
    exp_data = is_load(op) ? rdata : res;
    n_cmp++;
    if ({wb_valid, wb_data, wb_dst} !== {1'b1, exp_data, dst}) begin
      n_bad++; $display("FAIL done_data op%h: got v%b %h/%h want v1 %h/%h", op, wb_valid, wb_data, wb_dst, exp_data, dst);
    end
    n_cmp++;
    if ({wb_we, wb_ret} !== {op == OP_LW, op == OP_RET}) begin
      n_bad++; $display("FAIL done_we_ret op%h: got %b%b want %b%b", op, wb_we, wb_ret, op == OP_LW, op == OP_RET);
    end
    n_cmp++;
    if ({mem_stall, dmem_req, mem_err} !== 3'b000) begin
      n_bad++; $display("FAIL done_ctrl op%h: got %b want 000", op, {mem_stall, dmem_req, mem_err});
    end
  endtask

  task automatic test_store();
    mem_txn(OP_SW, 16'hF044, 16'hCAFE, 4'h2, 3, 16'h0BAD);
  endtask

  task automatic test_load_ret();
    mem_txn(OP_LW, 16'hBA55, 16'h7777, 4'h6, 0, 16'h1234);
    mem_txn(OP_RET, 16'h1235, 16'h0000, 4'hF, 1, 16'h00A0);
    mem_txn(OP_CALL, 16'h0FF0, 16'h0101, 4'hF, 2, 16'h5555);
  endtask

  task automatic test_random_mem();
    for (int i = 0; i < 12; i++)
      mem_txn(mem_ops[$urandom_range(0, 3)], 16'($urandom), 16'($urandom), 4'($urandom),
              int'($urandom_range(0, 5)), 16'($urandom));
  endtask

  task automatic test_back_to_back();
    mem_txn(OP_LW, 16'hBA55, 16'h0000, 4'h4, 0, 16'h1234);
    @(negedge clk);
    ex_valid = 1'b1; ex_instr = {OP_ADD, 4'h3, 8'h12}; ex_result = 16'h0003; ex_rt = 16'h0;
    dmem_ready = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if ({wb_valid, wb_data, wb_dst, wb_we, mem_stall} !== {1'b1, 16'h0003, 4'h3, 1'b1, 1'b0}) begin
      n_bad++; $display("FAIL b2b_add: got v%b %h/%h we%b st%b want v1 0003/3 we1 st0", wb_valid, wb_data, wb_dst, wb_we, mem_stall);
    end
    mem_txn(OP_SW, 16'h0100, 16'hABCD, 4'h1, 0, 16'h0);
    mem_txn(OP_LW, 16'h0100, 16'h0000, 4'h7, 1, 16'hABCD);
    @(negedge clk);
    ex_valid = 1'b0; dmem_ready = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if ({wb_valid, wb_we} !== 2'b00) begin
      n_bad++; $display("FAIL wb_pulse: got %b want 00", {wb_valid, wb_we});
    end
  endtask

  task automatic test_rst_access();
    @(negedge clk);
    ex_valid = 1'b1; ex_instr = {OP_SW, 4'h2, 8'h00}; ex_result = 16'hF044; ex_rt = 16'hCAFE;
    dmem_ready = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if ({mem_stall, dmem_req} !== 2'b11) begin
      n_bad++; $display("FAIL rst_pre: got %b want 11", {mem_stall, dmem_req});
    end
    @(negedge clk);
    ex_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({mem_stall, dmem_req, dmem_we, wb_valid} !== 4'b0000) begin
      n_bad++; $display("FAIL rst_abort: got %b want 0000", {mem_stall, dmem_req, dmem_we, wb_valid});
    end
    @(negedge clk);
    rst = 1'b0; dmem_ready = 1'b1; dmem_rdata = 16'h9999;
    @(posedge clk); #1;
    n_cmp++;
    if ({wb_valid, dmem_req, mem_stall} !== 3'b000) begin
      n_bad++; $display("FAIL rst_late_ready: got %b want 000", {wb_valid, dmem_req, mem_stall});
    end
    @(negedge clk);
    dmem_ready = 1'b0;
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout();
    // Ready arriving on the would-be timeout edge wins.
    mem_txn(OP_LW, 16'h4000, 16'h0, 4'h9, 14, 16'h600D);
    @(negedge clk);
    ex_valid = 1'b1; ex_instr = {OP_LW, 4'h8, 8'h00}; ex_result = 16'h2468; ex_rt = 16'h0;
    dmem_ready = 1'b0;
    @(posedge clk); #1;
    for (int k = 1; k < 15; k++) begin
      @(negedge clk);
      ex_valid = 1'b0;
      @(posedge clk); #1;
      n_cmp++;
      if ({mem_stall, dmem_req, mem_err} !== 3'b110) begin
        n_bad++; $display("FAIL to_wait[%0d]: got %b want 110", k, {mem_stall, dmem_req, mem_err});
      end
    end
    @(negedge clk);
    @(posedge clk); #1;
    n_cmp++;
    if ({wb_valid, wb_data, wb_dst, mem_err, mem_stall, dmem_req} !== {1'b1, 16'hDEAD, 4'h8, 1'b1, 1'b0, 1'b0}) begin
      n_bad++; $display("FAIL to_fire: got v%b %h/%h err%b st%b req%b want v1 dead/8 err1 st0 req0",
                        wb_valid, wb_data, wb_dst, mem_err, mem_stall, dmem_req);
    end
    @(negedge clk);
    ex_valid = 1'b1; ex_instr = {OP_ADD, 4'h1, 8'h00}; ex_result = 16'h0042;
    @(posedge clk); #1;
    n_cmp++;
    if ({mem_err, wb_data} !== {1'b1, 16'h0042}) begin
      n_bad++; $display("FAIL to_sticky: got err%b %h want err1 0042", mem_err, wb_data);
    end
    @(negedge clk);
    ex_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (mem_err !== 1'b0) begin n_bad++; $display("FAIL to_clear: got %b want 0", mem_err); end
    @(negedge clk);
    rst = 1'b0;
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_alu();
    test_store();
    test_load_ret();
    test_back_to_back();
    test_random_mem();
    test_rst_access();
`ifdef MEM_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory stage of the 16-bit pipeline. It sits directly downstream of the EX stage and consumes its `result`, `rt` and instruction.
- Registers the EX outputs (EX/MEM latch).
- Performs LW/SW/CALL/RET data-memory accesses over a ready-based handshake that may take several cycles, stalling upstream while an access is in flight.
- Presents a registered writeback bundle to WB.

Parameters:
- TIMEOUT_CYCLES, 15: max cycles an access may wait for dmem_ready (used only with MEM_TIMEOUT_EN).
- ERR_DATA, 16'hDEAD: wb_data value returned on a timed-out load.

Ports:
- clk  in  1  single clock; all state changes on posedge.
- rst  in  1  reset; synchronous and active-high.
- ex_valid  in  1  EX slot holds a real instruction (0 = bubble).
- ex_result  in  16  EX result (ALU value or memory address).
- ex_rt  in  16  EX store data (SW data, CALL return address).
- ex_instr  in  16  instruction; [15:12] opcode per opcode.h macros, [11:8] destination.
- mem_stall  out  1  upstream must hold EX and not advance.
- dmem_req  out  1  memory request active.
- dmem_we  out  1  1 = write, 0 = read.
- dmem_addr  out  16  word address.
- dmem_wdata  out  16  write data.
- dmem_rdata  in  16  read data; valid when dmem_ready=1.
- dmem_ready  in  1  access completes at this edge.
- wb_valid  out  1  writeback bundle valid.
- wb_data  out  16  value to write or load result.
- wb_dst  out  4  destination register (ex_instr[11:8]).
- wb_we  out  1  register-file write enable.
- wb_ret  out  1  wb_data is a RET return address for PC load.
- mem_err  out  1  sticky timeout flag.

Behaviour:
- Reset: on a posedge with rst=1, the FSM goes to IDLE and all outputs (including mem_err and the stage registers) become 0. Reset overrides everything, including an in-flight access. A pending dmem_ready is ignored.
- FSM states: IDLE, ACCESS.
- Accept: at a posedge in IDLE with rst=0, latch ex_valid/result/rt/instr.
  - Loads are LW and RET. Stores are SW and CALL.
  - If ex_valid=1 and the opcode is a load or store, go to ACCESS.
  - Otherwise stay in IDLE and produce writeback at the same edge.
- Non-memory ops (ADD, SUB, NAND, XOR, INC, SRA, SRL, SLL, LHB, LLB, B): 1-cycle latency.
  - wb_valid=1, wb_data=ex_result, wb_dst=ex_instr[11:8], wb_we=1.
  - For B: wb_we=0.
- Bubble (ex_valid=0): wb_valid=0 and wb_we=0 at the next edge.
- ACCESS outputs (all driven from registers):
  - dmem_req=1; dmem_addr=latched result.
  - dmem_we=1 for SW/CALL; dmem_wdata=latched rt.
  - All four are held stable until completion.
  - mem_stall=1 (combinational: state==ACCESS). EX is not latched while mem_stall=1.
  - wb_valid=0 each cycle spent in ACCESS.
- Completion (posedge in ACCESS with dmem_ready=1): return to IDLE, dmem_req=0, wb_valid=1.
  - LW: wb_data=dmem_rdata, wb_we=1.
  - RET: wb_data=dmem_rdata, wb_we=0, wb_ret=1.
  - SW/CALL: wb_data=latched result, wb_we=0.
  - Minimum memory latency is 2 edges from accept to wb_valid.
- wb_ret=0 except on RET completion. wb_valid is a one-cycle pulse per instruction.
- dmem_ready=1 in IDLE is ignored. dmem_rdata is sampled only at the completion edge.
- The first edge after completion is an accept edge; back-to-back memory ops are allowed.
- Addresses are 16-bit, with no wrap handling; the address is used as given.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Enabled:
  - A 4-bit-or-wider wait counter clears on entering ACCESS and increments each ACCESS cycle without dmem_ready.
  - If the counter reaches TIMEOUT_CYCLES with no ready, the stage forces completion at that edge:
    - state goes to IDLE and dmem_req drops;
    - mem_err sets and stays set until rst;
    - a load returns wb_data=ERR_DATA, while the store is dropped;
    - wb_valid is asserted as normal.
  - If ready and timeout occur at the same edge, ready wins and mem_err is not set.
- Disabled: no counter, ACCESS waits indefinitely, and mem_err is tied to 0.

Test Plan:
- ADD, ex_result=0003, dst=3 → next edge: wb_valid=1, wb_data=0003, wb_dst=3, wb_we=1, mem_stall=0.
- SW, result=F044, rt=CAFE, ready held low 3 cycles → dmem_req=1, we=1, addr=F044, wdata=CAFE stable, mem_stall=1 for 4 cycles. Then wb_valid=1, wb_we=0.
- LW, result=BA55, ready on the first ACCESS edge with rdata=1234 → wb_data=1234, wb_we=1, 2-edge latency. A following ADD is accepted the next edge.
- RET, result=1235, rdata=00A0 → wb_ret=1, wb_data=00A0, wb_we=0.
- rst during ACCESS of SW → dmem_req=0, wb_valid=0, state IDLE. A later dmem_ready pulse produces no writeback.
- With MEM_TIMEOUT_EN, LW, ready never asserted → after 15 ACCESS cycles: wb_data=DEAD, mem_err=1 (sticky), mem_stall=0.
